// File: rtl/spm_ctx_if.sv
// Host/config-side and scratchpad-side signals of the context sequencer.
// master = host/config fetch path (and bench); slave = the sequencer itself.
interface spm_ctx_if #(
  parameter int INST_W = 20,
  parameter int CNT_W  = 8,
  parameter int NUM_W  = 6
);

  logic                      start;
  logic                      abort;
  logic [NUM_W-1:0]          num_ctx;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [INST_W+CNT_W-1:0]   cfg_data;
  logic                      spm_rst;
  logic                      spm_init;
  logic                      spm_run;
  logic [INST_W-1:0]         spm_inst;
  logic [NUM_W-1:0]          ctx_idx;
  logic                      busy;
  logic                      done;

  modport master (
    output start, abort, num_ctx, cfg_valid, cfg_data,
    input  cfg_ready, spm_rst, spm_init, spm_run, spm_inst, ctx_idx, busy, done
  );

  modport slave (
    input  start, abort, num_ctx, cfg_valid, cfg_data,
    output cfg_ready, spm_rst, spm_init, spm_run, spm_inst, ctx_idx, busy, done
  );

endinterface

// File: rtl/spm_ctx_sequencer.sv
// Loads NUM context words into the scratchpad config buffer, then steps the
// scratchpad through each context with a run pulse plus a per-context dwell.
module spm_ctx_sequencer #(
  parameter int INST_W = 20,
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 32,
  parameter int NUM_W  = 6
) (
  input  logic     clk,
  input  logic     rst,
  spm_ctx_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_RUN,
    S_HOLD,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_W-1:0]  n_q;
  logic [NUM_W-1:0]  ctx_q;
  logic [CNT_W-1:0]  hold_q;
  logic [INST_W-1:0] inst_q;
  logic [CNT_W-1:0]  dwell_tbl [DEPTH];

  logic              load_ready;
  logic              xfer;
  logic              last_ctx;
  logic [NUM_W-1:0]  n_sat;
  logic [CNT_W-1:0]  cur_dwell;
  logic [CNT_W-1:0]  beat_dwell;
  logic [INST_W-1:0] beat_inst;

  logic              rst_pulse;
  logic              run_pulse;
  logic              done_pulse;

  assign beat_inst  = bus.cfg_data[INST_W-1:0];
  assign beat_dwell = bus.cfg_data[INST_W +: CNT_W];

  assign n_sat      = (bus.num_ctx > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : bus.num_ctx;
  assign load_ready = (state_q == S_LOAD);
  // A beat coincident with abort is still consumed, so abort does not gate xfer.
  assign xfer       = bus.cfg_valid & load_ready;
  assign last_ctx   = (ctx_q == (n_q - NUM_W'(1)));
  assign cur_dwell  = dwell_tbl[ctx_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_d    = state_q;
    rst_pulse  = 1'b0;
    run_pulse  = 1'b0;
    done_pulse = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = (n_sat == '0) ? S_FIN : S_CLR;
      end
      S_CLR: begin
        rst_pulse = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        if (xfer && last_ctx) state_d = S_RUN;
      end
      S_RUN: begin
        run_pulse = 1'b1;
        if (cur_dwell != '0) state_d = S_HOLD;
        else if (last_ctx)   state_d = S_FIN;
      end
      S_HOLD: begin
        if (hold_q == CNT_W'(1)) state_d = last_ctx ? S_FIN : S_RUN;
      end
      S_FIN: begin
        done_pulse = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition and silences the strobes of this cycle.
    if (bus.abort) begin
      state_d    = S_IDLE;
      rst_pulse  = 1'b0;
      run_pulse  = 1'b0;
      done_pulse = 1'b0;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      ctx_q     <= '0;
      hold_q    <= '0;
      inst_q    <= '0;
      // NOTE: the dwell table is a small flop array, so it is cleared with the
      // rest of the state instead of being left uninitialised like a RAM.
      dwell_tbl <= '{default: '0};
    end else begin
      if (state_q == S_IDLE && bus.start) n_q <= n_sat;

      if (state_q == S_CLR) ctx_q <= '0;

      if (xfer) begin
        dwell_tbl[ctx_q[AW-1:0]] <= beat_dwell;
        inst_q                   <= beat_inst;
        ctx_q                    <= last_ctx ? '0 : ctx_q + NUM_W'(1);
      end

      if (state_q == S_RUN && !bus.abort) begin
        if (cur_dwell == '0) begin
          if (!last_ctx) ctx_q <= ctx_q + NUM_W'(1);
        end else begin
          hold_q <= cur_dwell;
        end
      end

      if (state_q == S_HOLD && !bus.abort) begin
        if (hold_q == CNT_W'(1)) begin
          if (!last_ctx) ctx_q <= ctx_q + NUM_W'(1);
        end else begin
          hold_q <= hold_q - CNT_W'(1);
        end
      end
    end
  end

  // The inst field is forwarded combinationally on a transfer and held otherwise.
  assign bus.spm_inst  = xfer ? beat_inst : inst_q;
  assign bus.spm_init  = xfer;
  assign bus.spm_run   = run_pulse;
  assign bus.spm_rst   = rst_pulse;
  assign bus.cfg_ready = load_ready;
  assign bus.ctx_idx   = ctx_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_pulse;

endmodule

// File: tb/tb_spm_ctx_sequencer.sv
// Self-checking bench for spm_ctx_sequencer: a cycle-level event model built
// from the load/run timing rules is compared against the observed strobes.
module tb_spm_ctx_sequencer;

  localparam int INST_W = 20;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 32;
  localparam int NUM_W  = 6;
  localparam int NB     = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spm_ctx_if #(.INST_W(INST_W), .CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

  spm_ctx_sequencer #(
    .INST_W(INST_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .NUM_W(NUM_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Beat table and cfg_valid pattern
  logic [INST_W-1:0] b_inst  [NB];
  int                b_dwell [NB];
  bit                vpat    [4096];

  // Observed events, relative to the start cycle
  int cyc = 0;
  int t0  = 0;
  bit logging = 1'b0;
  int rel_m;
  int q_rst[$], q_init_c[$], q_run_c[$], q_run_ctx[$], q_done[$];
  logic [INST_W-1:0] q_init_v[$];
  int n_busy, n_ready, n_xfer, n_overlap;

  // Expected events
  int e_rst[$], e_init_c[$], e_run_c[$], e_run_ctx[$], e_done[$];
  logic [INST_W-1:0] e_init_v[$];
  int e_busy, e_ready;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (logging) begin
      rel_m = cyc - t0;
      if (bus.spm_rst)  q_rst.push_back(rel_m);
      if (bus.spm_init) begin
        q_init_c.push_back(rel_m);
        q_init_v.push_back(bus.spm_inst);
      end
      if (bus.spm_run) begin
        q_run_c.push_back(rel_m);
        q_run_ctx.push_back(int'(bus.ctx_idx));
      end
      if (bus.done)      q_done.push_back(rel_m);
      if (bus.busy)      n_busy++;
      if (bus.cfg_ready) n_ready++;
      if (bus.cfg_valid && bus.cfg_ready) n_xfer++;
      if (bus.spm_init && bus.spm_run)    n_overlap++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit valid_at(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 1;
      default: return vpat[c % 4096];
    endcase
  endfunction

  // Expected trace: CLR at 1, beats accepted at valid cycles from 2 on, then
  // context k runs for 1+dwell[k] cycles, FIN right after. A cut (abort or
  // reset) at cycle X keeps the strobes before X (and a load beat taken at X).
  task automatic build_model(input int num, input int mode, input int cut, output int last_rel);
    int n, c, t, load_end;
    e_rst.delete(); e_init_c.delete(); e_init_v.delete();
    e_run_c.delete(); e_run_ctx.delete(); e_done.delete();
    n = (num > DEPTH) ? DEPTH : num;
    t = 1;
    load_end = 1;
    if (n > 0) begin
      if (cut < 0 || 1 < cut) e_rst.push_back(1);
      c = 2;
      for (int k = 0; k < n; k++) begin
        while (!valid_at(mode, c)) c++;
        if (cut < 0 || c <= cut) begin
          e_init_c.push_back(c);
          e_init_v.push_back(b_inst[k]);
        end
        c++;
      end
      load_end = c - 1;
      t = c;
      for (int k = 0; k < n; k++) begin
        if (cut < 0 || t < cut) begin
          e_run_c.push_back(t);
          e_run_ctx.push_back(k);
        end
        t += 1 + b_dwell[k];
      end
    end
    if (cut < 0 || t < cut) e_done.push_back(t);
    e_busy  = (cut >= 0 && cut < t) ? cut : t;
    e_ready = (n == 0) ? 0 : ((cut >= 0 && cut < load_end) ? cut - 1 : load_end - 1);
    last_rel = (cut >= 0) ? cut + 3 : t + 2;
  endtask

  task automatic run_seq(input string tag, input int num, input int mode, input int cut,
                         input bit cut_rst, input int restart_at);
    int last_rel;
    int bi;
    bit xfer;
    build_model(num, mode, cut, last_rel);
    q_rst.delete(); q_init_c.delete(); q_init_v.delete();
    q_run_c.delete(); q_run_ctx.delete(); q_done.delete();
    n_busy = 0; n_ready = 0; n_xfer = 0; n_overlap = 0;
    bi = 0;

    @(posedge clk); #1;
    t0 = cyc;
    logging = 1'b1;
    bus.start     = 1'b1;
    bus.num_ctx   = NUM_W'(num);
    bus.abort     = 1'b0;
    bus.cfg_valid = valid_at(mode, 0);
    bus.cfg_data  = {CNT_W'(b_dwell[0]), b_inst[0]};
    for (int r = 0; r < last_rel; r++) begin
      @(negedge clk);
      xfer = bus.cfg_valid && bus.cfg_ready;
      @(posedge clk); #1;
      if (xfer && bi < NB - 1) bi++;
      bus.start     = (r + 1 == restart_at);
      bus.abort     = (r + 1 == cut) && !cut_rst;
      rst           = (r + 1 == cut) && cut_rst;
      bus.cfg_valid = valid_at(mode, r + 1);
      bus.cfg_data  = {CNT_W'(b_dwell[bi]), b_inst[bi]};
    end
    @(negedge clk);
    chk({tag, "/idle_busy"},  64'(bus.busy),      64'(0));
    chk({tag, "/idle_ready"}, 64'(bus.cfg_ready), 64'(0));
    chk({tag, "/idle_done"},  64'(bus.done),      64'(0));
    if (cut_rst) begin
      chk({tag, "/rst_inst"}, 64'(bus.spm_inst), 64'(0));
      chk({tag, "/rst_ctx"},  64'(bus.ctx_idx),  64'(0));
    end
    #1;
    logging = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b0;

    chk({tag, "/rst_cnt"}, 64'(q_rst.size()), 64'(e_rst.size()));
    foreach (e_rst[i]) if (i < q_rst.size()) chk({tag, "/rst_cyc"}, 64'(q_rst[i]), 64'(e_rst[i]));
    chk({tag, "/init_cnt"}, 64'(q_init_c.size()), 64'(e_init_c.size()));
    foreach (e_init_c[i]) if (i < q_init_c.size()) begin
      chk({tag, "/init_cyc"},  64'(q_init_c[i]), 64'(e_init_c[i]));
      chk({tag, "/init_inst"}, 64'(q_init_v[i]), 64'(e_init_v[i]));
    end
    chk({tag, "/run_cnt"}, 64'(q_run_c.size()), 64'(e_run_c.size()));
    foreach (e_run_c[i]) if (i < q_run_c.size()) begin
      chk({tag, "/run_cyc"}, 64'(q_run_c[i]),   64'(e_run_c[i]));
      chk({tag, "/run_ctx"}, 64'(q_run_ctx[i]), 64'(e_run_ctx[i]));
    end
    chk({tag, "/done_cnt"}, 64'(q_done.size()), 64'(e_done.size()));
    foreach (e_done[i]) if (i < q_done.size()) chk({tag, "/done_cyc"}, 64'(q_done[i]), 64'(e_done[i]));
    chk({tag, "/busy_cyc"},  64'(n_busy),    64'(e_busy));
    chk({tag, "/ready_cyc"}, 64'(n_ready),   64'(e_ready));
    chk({tag, "/xfer_cnt"},  64'(n_xfer),    64'(e_init_c.size()));
    chk({tag, "/overlap"},   64'(n_overlap), 64'(0));
  endtask

  task automatic rand_beats(input int max_dwell);
    for (int i = 0; i < NB; i++) begin
      b_inst[i]  = INST_W'($urandom);
      b_dwell[i] = int'($urandom_range(0, max_dwell));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_ctx = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data = '0;
    for (int i = 0; i < 4096; i++) vpat[i] = bit'($urandom_range(0, 1));
    rand_beats(3);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/busy",     64'(bus.busy),      64'(0));
    chk("reset/done",     64'(bus.done),      64'(0));
    chk("reset/ready",    64'(bus.cfg_ready), 64'(0));
    chk("reset/spm_rst",  64'(bus.spm_rst),   64'(0));
    chk("reset/spm_init", 64'(bus.spm_init),  64'(0));
    chk("reset/spm_run",  64'(bus.spm_run),   64'(0));
    chk("reset/spm_inst", 64'(bus.spm_inst),  64'(0));
    chk("reset/ctx_idx",  64'(bus.ctx_idx),   64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Three contexts with dwell 0/2/1, no stalls: fixed cycle numbers
    b_inst[0] = 20'h00011; b_dwell[0] = 0;
    b_inst[1] = 20'h00122; b_dwell[1] = 2;
    b_inst[2] = 20'h00F33; b_dwell[2] = 1;
    run_seq("basic", 3, 0, -1, 1'b0, -1);
    if (q_run_c.size() == 3) begin
      chk("basic/run0_at5", 64'(q_run_c[0]), 64'(5));
      chk("basic/run1_at6", 64'(q_run_c[1]), 64'(6));
      chk("basic/run2_at9", 64'(q_run_c[2]), 64'(9));
    end
    if (q_done.size() == 1) chk("basic/done_at11", 64'(q_done[0]), 64'(11));

    // Two contexts with cfg_valid toggling
    rand_beats(4);
    run_seq("toggle", 2, 1, -1, 1'b0, -1);

    // Zero contexts
    run_seq("zero", 0, 0, -1, 1'b0, -1);

    // Saturation: 40 requested, 32 loaded and run
    rand_beats(3);
    run_seq("sat40", 40, 0, -1, 1'b0, -1);

    // Abort in HOLD of context 1 (dwell 5), then a full restart
    b_inst[0] = 20'h0A001; b_dwell[0] = 0;
    b_inst[1] = 20'h0A002; b_dwell[1] = 5;
    b_inst[2] = 20'h0A003; b_dwell[2] = 1;
    run_seq("abort", 3, 0, 8, 1'b0, -1);
    rand_beats(3);
    run_seq("after_abort", 3, 2, -1, 1'b0, -1);

    // start while busy is ignored; includes a full-range dwell
    rand_beats(2);
    b_dwell[1] = 255;
    run_seq("restart_busy", 4, 2, -1, 1'b0, 7);

    // Reset during LOAD, then a fresh run
    rand_beats(3);
    run_seq("rst_load", 3, 0, 3, 1'b1, -1);
    rand_beats(3);
    run_seq("after_rst", 3, 1, -1, 1'b0, -1);

    // Random runs
    for (int i = 0; i < 3; i++) begin
      rand_beats(6);
      run_seq("random", int'($urandom_range(1, 12)), 2, -1, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
